// File: rtl/io_device_responder.sv
// io_device_responder: serves processor input/output requests on 4 switch/button/display channels.
// Latency: press accepted 2+DEBOUNCE_CYCLES after a clean edge, out_done after OUT_HOLD_CYCLES; backpressure: level four-phase handshakes, one request at a time.
module io_device_responder #(
  parameter int CHANNELS        = 4,
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OUT_HOLD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_req,
  input  logic [1:0]                 in_chan,
  output logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       new_out,
  input  logic [1:0]                 out_chan,
  input  logic [DATA_W-1:0]          out_word,
  output logic                       out_done,
  input  logic [CHANNELS*DATA_W-1:0] sw,
  input  logic [CHANNELS-1:0]        enter_btn,
  output logic [CHANNELS*DATA_W-1:0] disp,
  output logic [CHANNELS-1:0]        disp_valid,
  output logic                       busy,
  output logic [2:0]                 state
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(OUT_HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_PRESS   = 3'd1,
    WAIT_RELEASE = 3'd2,
    IN_ACK       = 3'd3,
    OUT_HOLD     = 3'd4,
    OUT_ACK      = 3'd5
  } state_t;

  state_t                          cur_state, nxt_state;
  logic [CHANNELS-1:0]             sync1, sync2, db, db_nxt;
  logic [CHANNELS-1:0][CNT_W-1:0]  db_cnt, db_cnt_nxt;
  logic [1:0]                      chan;
  logic [HOLD_W-1:0]               hold_cnt;
  logic [DATA_W-1:0]               sw_sel;
  logic                            press_edge, db_sel;

  // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      db_nxt[k]     = db[k];
      db_cnt_nxt[k] = '0;
      if (sync2[k] != db[k]) begin
        if (db_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_nxt[k] = sync2[k];
        end else begin
          db_cnt_nxt[k] = db_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_cnt <= '0;
    end else begin
      sync1  <= enter_btn;
      sync2  <= sync1;
      db     <= db_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // Edge taken from the level being accepted this cycle, so capture lands with the debounce update.
  assign press_edge = db_nxt[chan] & ~db[chan];
  assign db_sel     = db_nxt[chan];
  assign sw_sel     = sw[chan*DATA_W +: DATA_W];

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (new_out)     nxt_state = OUT_HOLD;
        else if (in_req) nxt_state = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!in_req)         nxt_state = IDLE;
        else if (press_edge) nxt_state = WAIT_RELEASE;
      end
      WAIT_RELEASE: if (!db_sel) nxt_state = IN_ACK;
      IN_ACK:       if (!in_req) nxt_state = IDLE;
      OUT_HOLD:     if (hold_cnt == HOLD_W'(OUT_HOLD_CYCLES - 1)) nxt_state = OUT_ACK;
      OUT_ACK:      if (!new_out) nxt_state = IDLE;
      default:      nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= IDLE;
      chan       <= '0;
      hold_cnt   <= '0;
      in_data    <= '0;
      in_ready   <= 1'b0;
      out_done   <= 1'b0;
      disp       <= '0;
      disp_valid <= '0;
    end else begin
      cur_state <= nxt_state;
      in_ready  <= (nxt_state == IN_ACK);
      out_done  <= (nxt_state == OUT_ACK);
      if (cur_state == IDLE) begin
        hold_cnt <= '0;
        if (new_out) begin
          // Display is written on entry so it is visible in the first hold cycle.
          chan                               <= out_chan;
          disp[out_chan*DATA_W +: DATA_W]    <= out_word;
          disp_valid[out_chan]               <= 1'b1;
        end else if (in_req) begin
          chan <= in_chan;
        end
      end
      if (cur_state == OUT_HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (cur_state == WAIT_PRESS && nxt_state == WAIT_RELEASE) in_data <= sw_sel;
    end
  end

  assign busy  = (cur_state != IDLE);
  assign state = cur_state;

endmodule

// File: tb/tb_io_device_responder.sv
// Randomized scenario bench for io_device_responder against a behavioural model of channel words and timing.
module tb_io_device_responder;

  localparam int DEB       = 16;
  localparam int HOLD      = 4;
  localparam int PRESS_LAT = 2 + DEB;  // two synchronizer stages then the stable run

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_req, new_out;
  logic [1:0]   in_chan, out_chan;
  logic [31:0]  out_word, in_data;
  logic         in_ready, out_done, busy;
  logic [127:0] sw, disp;
  logic [3:0]   enter_btn, disp_valid;
  logic [2:0]   state;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_disp [4];
  logic [3:0]  m_valid;
  logic [31:0] m_in_data;

  io_device_responder dut (
    .clk(clk), .rst_n(rst_n),
    .in_req(in_req), .in_chan(in_chan), .in_data(in_data), .in_ready(in_ready),
    .new_out(new_out), .out_chan(out_chan), .out_word(out_word), .out_done(out_done),
    .sw(sw), .enter_btn(enter_btn), .disp(disp), .disp_valid(disp_valid),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (in_ready && out_done) begin
        errors++;
        $display("FAIL handshake_exclusive in_ready=%b out_done=%b required not both", in_ready, out_done);
      end
    end
  end

  function automatic logic [127:0] model_disp();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = m_disp[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_req    = 1'($urandom);
    new_out   = 1'($urandom);
    in_chan   = 2'($urandom);
    out_chan  = 2'($urandom);
    out_word  = $urandom;
    enter_btn = 4'($urandom);
    sw        = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (in_ready !== 1'b0 || out_done !== 1'b0) begin errors++; $display("FAIL reset_handshake got %b%b exp 00", in_ready, out_done); end
    checks++; if (in_data !== 32'h0) begin errors++; $display("FAIL reset_in_data got %h exp 0", in_data); end
    checks++; if (disp !== 128'h0 || disp_valid !== 4'h0) begin errors++; $display("FAIL reset_disp got %h/%b exp 0", disp, disp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    in_req = 1'b0; new_out = 1'b0; enter_btn = 4'h0;
    for (int i = 0; i < 4; i++) m_disp[i] = 32'h0;
    m_valid = 4'h0; m_in_data = 32'h0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL post_reset_idle busy=%b state=%0d exp 0/0", busy, state); end
  endtask

  // Full input transaction: optional distractor press, then a clean press of press_len cycles.
  task automatic run_input(input int c, input logic [31:0] w, input int press_len, input bit distract, input string name);
    int cap_t, rdy_t, d;
    bit bad;
    sw = {$urandom, $urandom, $urandom, $urandom};
    sw[c*32 +: 32] = w;
    in_req = 1'b1; in_chan = 2'(c);
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL %s_wait_press got %0d exp 1", name, state); end
    if (distract) begin
      d = (c + 1) % 4;
      bad = 1'b0;
      enter_btn[d] = 1'b1;
      repeat (25) begin tick(); if (state !== 3'd1) bad = 1'b1; end
      enter_btn[d] = 1'b0;
      checks++; if (bad) begin errors++; $display("FAIL %s_other_chan_ignored state=%0d exp 1", name, state); end
    end
    cap_t = -1; rdy_t = -1;
    enter_btn[c] = 1'b1;
    for (int t = 1; t <= press_len + PRESS_LAT + 2; t++) begin
      tick();
      if (state === 3'd2 && cap_t < 0) cap_t = t;
      if (in_ready === 1'b1 && rdy_t < 0) rdy_t = t;
      if (t == press_len) enter_btn[c] = 1'b0;
    end
    checks++; if (cap_t != PRESS_LAT) begin errors++; $display("FAIL %s_capture_cycle got %0d exp %0d", name, cap_t, PRESS_LAT); end
    checks++; if (rdy_t != press_len + PRESS_LAT) begin errors++; $display("FAIL %s_ready_cycle got %0d exp %0d", name, rdy_t, press_len + PRESS_LAT); end
    checks++; if (in_data !== w || in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_data got %h/%b exp %h/1", name, in_data, in_ready, w); end
    m_in_data = w;
    in_req = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL %s_ack_drop got %b/%0d exp 0/0", name, in_ready, state); end
    checks++; if (in_data !== m_in_data) begin errors++; $display("FAIL %s_in_data_hold got %h exp %h", name, in_data, m_in_data); end
  endtask

  task automatic test_input_ch2();
    run_input(2, 32'hDEADBEEF, 40, 1'b0, "input_ch2");
  endtask

  task automatic test_input_random();
    for (int i = 0; i < 4; i++)
      run_input(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(20, 50)), 1'($urandom), "input_rand");
  endtask

  task automatic test_bounce();
    int caps, cap_t, n;
    logic [2:0] prev;
    sw = {$urandom, $urandom, $urandom, $urandom};
    in_req = 1'b1; in_chan = 2'd0;
    tick();
    caps = 0; cap_t = -1; prev = state;
    // 60 cycles toggling every 5, then steady high from cycle 60
    for (int k = 0; k < 80; k++) begin
      enter_btn[0] = (k >= 60) ? 1'b1 : (((k / 5) % 2) == 0);
      tick();
      if (prev === 3'd1 && state === 3'd2) begin caps++; if (cap_t < 0) cap_t = k + 1; end
      prev = state;
    end
    checks++; if (caps != 1) begin errors++; $display("FAIL bounce_capture_count got %0d exp 1", caps); end
    checks++; if (cap_t != 60 + PRESS_LAT) begin errors++; $display("FAIL bounce_capture_cycle got %0d exp %0d", cap_t, 60 + PRESS_LAT); end
    enter_btn[0] = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 60) begin tick(); n++; end
    checks++; if (in_ready !== 1'b1 || in_data !== sw[31:0]) begin errors++; $display("FAIL bounce_ack got %b/%h exp 1/%h", in_ready, in_data, sw[31:0]); end
    m_in_data = sw[31:0];
    in_req = 1'b0;
    tick();
  endtask

  task automatic run_output(input int c, input logic [31:0] w, input bit drop_early, input string name);
    int done_t;
    new_out = 1'b1; out_chan = 2'(c); out_word = w;
    tick();
    m_disp[c] = w; m_valid[c] = 1'b1;
    checks++; if (disp !== model_disp() || disp_valid !== m_valid) begin errors++; $display("FAIL %s_disp got %h/%b exp %h/%b", name, disp, disp_valid, model_disp(), m_valid); end
    checks++; if (state !== 3'd4 || out_done !== 1'b0) begin errors++; $display("FAIL %s_hold got %0d/%b exp 4/0", name, state, out_done); end
    out_word = $urandom;
    out_chan = 2'($urandom);
    if (drop_early) new_out = 1'b0;
    done_t = -1;
    for (int t = 2; t <= 1 + HOLD; t++) begin
      tick();
      if (out_done === 1'b1 && done_t < 0) done_t = t;
    end
    checks++; if (done_t != 1 + HOLD) begin errors++; $display("FAIL %s_done_cycle got %0d exp %0d", name, done_t, 1 + HOLD); end
    new_out = 1'b0;
    tick();
    checks++; if (out_done !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL %s_done_drop got %b/%0d exp 0/0", name, out_done, state); end
    checks++; if (disp !== model_disp()) begin errors++; $display("FAIL %s_disp_hold got %h exp %h", name, disp, model_disp()); end
  endtask

  task automatic test_output_ch1();
    run_output(1, 32'h00000042, 1'b0, "output_ch1");
    checks++; if (disp_valid !== 4'b0010) begin errors++; $display("FAIL output_ch1_valid got %b exp 0010", disp_valid); end
  endtask

  task automatic test_output_random();
    for (int i = 0; i < 5; i++)
      run_output(int'($urandom_range(0, 3)), $urandom, 1'($urandom), "output_rand");
  endtask

  task automatic test_simultaneous();
    logic [31:0] w;
    w = $urandom;
    in_req = 1'b1; in_chan = 2'd3;
    new_out = 1'b1; out_chan = 2'd0; out_word = w;
    tick();
    m_disp[0] = w; m_valid[0] = 1'b1;
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL simul_output_first got %0d exp 4", state); end
    repeat (HOLD) tick();
    checks++; if (out_done !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL simul_out_done got %b/%b exp 1/0", out_done, in_ready); end
    new_out = 1'b0;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL simul_back_idle got %0d exp 0", state); end
    tick();
    checks++; if (state !== 3'd1 || disp !== model_disp()) begin errors++; $display("FAIL simul_input_next got %0d exp 1", state); end
    in_req = 1'b0;
    tick();
    checks++; if (state !== 3'd0 || in_data !== m_in_data) begin errors++; $display("FAIL simul_abort got %0d/%h exp 0/%h", state, in_data, m_in_data); end
  endtask

  task automatic test_abort_req();
    int c;
    c = int'($urandom_range(0, 3));
    sw = {$urandom, $urandom, $urandom, $urandom};
    in_req = 1'b1; in_chan = 2'(c);
    tick();
    enter_btn[c] = 1'b1;
    repeat (10) tick();
    in_req = 1'b0;
    tick();
    checks++; if (state !== 3'd0 || in_data !== m_in_data) begin errors++; $display("FAIL abort_req got %0d/%h exp 0/%h", state, in_data, m_in_data); end
    enter_btn[c] = 1'b0;
    repeat (30) tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL abort_req_quiet got %b/%b exp 0/0", busy, in_ready); end
  endtask

  task automatic test_late_drop();
    int c, n;
    logic [31:0] w;
    c = int'($urandom_range(0, 3));
    w = $urandom;
    sw = {$urandom, $urandom, $urandom, $urandom};
    sw[c*32 +: 32] = w;
    in_req = 1'b1; in_chan = 2'(c);
    tick();
    enter_btn[c] = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < 40) begin tick(); n++; end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL late_drop_capture got %0d exp 2", state); end
    in_req = 1'b0;
    enter_btn[c] = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (state !== 3'd3 || in_data !== w) begin errors++; $display("FAIL late_drop_ack got %0d/%h exp 3/%h", state, in_data, w); end
    m_in_data = w;
    tick();
    checks++; if (state !== 3'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL late_drop_idle got %0d/%b exp 0/0", state, in_ready); end
  endtask

  task automatic test_abort_reset();
    in_req = 1'b1; in_chan = 2'($urandom);
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL rst_mid_setup got %0d exp 1", state); end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_disp[i] = 32'h0;
    m_valid = 4'h0; m_in_data = 32'h0;
    checks++; if (state !== 3'd0 || in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_state got %0d/%b/%b exp 0/0/0", state, in_ready, busy); end
    checks++; if (disp !== model_disp() || disp_valid !== m_valid || in_data !== m_in_data) begin errors++; $display("FAIL rst_mid_regs got %h/%b/%h exp 0", disp, disp_valid, in_data); end
    in_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_mid_release got %0d exp 0", state); end
  endtask

  initial begin
    test_reset();
    test_input_ch2();
    test_output_ch1();
    test_bounce();
    test_input_random();
    test_output_random();
    test_simultaneous();
    test_abort_req();
    test_late_drop();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_device_responder.md
Name: io_device_responder

Overview:
Device-side responder for the processor's input/output request handshake. It serves input requests by waiting for a debounced enter press on the selected channel, capturing that channel's switch word and returning it with in_ready. It serves output requests by latching the processor's word into the selected channel's display register and returning out_done. It sits between the processor top and the board switches, buttons and displays, providing 4 channels of 32 bits each.

Parameters:
CHANNELS, 4, number of device channels (fixed at 4 for this revision)
DATA_W, 32, word width per channel
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a button level change
OUT_HOLD_CYCLES, 4, cycles the display write is held before out_done asserts

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
in_req  input  1  processor input request (level, held until in_ready observed)
in_chan  input  2  channel for the input request, sampled with in_req in IDLE
in_data  output  32  captured switch word, valid while in_ready=1
in_ready  output  1  input response handshake
new_out  input  1  processor output request (level)
out_chan  input  2  channel for the output request, sampled with new_out in IDLE
out_word  input  32  word to display, sampled with new_out in IDLE
out_done  output  1  output response handshake
sw  input  128  switch words; channel k occupies bits [32k+31:32k]
enter_btn  input  4  raw asynchronous enter buttons, active-high, one per channel
disp  output  128  display registers; channel k occupies bits [32k+31:32k]
disp_valid  output  4  per-channel flag: display written since reset
busy  output  1  high in any state other than IDLE
state  output  3  current FSM state encoding, for debug

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_data=0, in_ready=0, out_done=0, disp=0, disp_valid=0, busy=0; synchronizers, debounce counters and debounced levels cleared to 0.
- Button path: 2-FF synchronizer per bit. Debounced level db[k] takes the new synchronized value only after DEBOUNCE_CYCLES consecutive equal differing samples; any bounce restarts that counter. The accepted-press latency from a clean edge is 2+DEBOUNCE_CYCLES cycles.
- FSM state encodings: IDLE=0, WAIT_PRESS=1, WAIT_RELEASE=2, IN_ACK=3, OUT_HOLD=4, OUT_ACK=5.
- IDLE:
  - If new_out=1: latch out_chan and out_word, go to OUT_HOLD. Output has priority when new_out and in_req are both high.
  - Else if in_req=1: latch in_chan, go to WAIT_PRESS.
- WAIT_PRESS: on a 0->1 transition of db[chan], capture sw slice[chan] into in_data, go to WAIT_RELEASE. Presses on other channels are ignored. A press already held at request time is not accepted; a fresh edge is required.
- WAIT_RELEASE: when db[chan]=0, go to IN_ACK. This prevents one press from satisfying two requests.
- IN_ACK:
  - in_ready=1 and in_data stable; go to IDLE when in_req=0 (four-phase handshake).
  - in_ready drops in the same cycle as the IDLE transition.
- OUT_HOLD: in the first cycle, write disp slice[chan]=word and set disp_valid[chan]; after OUT_HOLD_CYCLES cycles total, go to OUT_ACK.
- OUT_ACK: out_done=1; go to IDLE when new_out=0.
- in_ready and out_done are registered outputs and are never high simultaneously.
- in_data holds its last captured value after the handshake; disp holds until rewritten or reset.
- Request drop mid-operation:
  - in_req falling while in WAIT_PRESS: abort to IDLE, in_data unchanged.
  - in_req falling while in WAIT_RELEASE: complete the release wait, then go to IN_ACK, then to IDLE on the next cycle.
  - new_out falling during OUT_HOLD: does not abort the write.
- Reset mid-operation: immediate return to reset values, including disp.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0, state=0; after release, busy=0.
- Input, channel 2:
  - Stimulus: sw[95:64]=32'hDEADBEEF, in_req=1, in_chan=2, then a clean enter_btn[2] pulse of 40 cycles.
  - Response: in_data=32'hDEADBEEF; in_ready rises only after the debounced release; in_ready clears one cycle after in_req drops.
- Bounce rejection, channel 0:
  - Stimulus: enter_btn[0] toggling every 5 cycles for 60 cycles during WAIT_PRESS, then stable high for 20 cycles.
  - Response: exactly one capture, and no capture before the stable period.
- Output, channel 1:
  - Stimulus: new_out=1, out_chan=1, out_word=32'h00000042.
  - Response: disp[63:32]=32'h42 one cycle after the request; disp_valid=4'b0010; out_done=1 on cycle 1+OUT_HOLD_CYCLES; out_done=0 one cycle after new_out drops.
- Simultaneous requests: in_req and new_out rise in the same cycle -> the output is served first; after new_out drops, the input request proceeds to WAIT_PRESS.
- Mid-operation abort and reset:
  - rst_n pulsed low during WAIT_PRESS -> returns to IDLE, in_ready=0, disp=0.
  - in_req dropped in WAIT_PRESS -> IDLE with in_data unchanged.
